fetch_ctrl: RTL

Instruction-fetch controller for the single-issue RISC-V core. It owns the program counter, issues word requests to instruction memory over a req/gnt/rvalid handshake, and buffers returned instructions with their PCs in a small queue for decode. It also applies branch/jump redirects from execute and discards in-flight responses belonging to the old stream.

---
 rtl/fetch_pkg.sv | 18 +
 rtl/fetch_ibuf.sv | 55 +++++
 rtl/fetch_ctrl.sv | 134 +++++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch controller.
package fetch_pkg;

    typedef logic [1:0] fetch_state_t;

    localparam fetch_state_t StIdle  = 2'd0;
    localparam fetch_state_t StRun   = 2'd1;
    localparam fetch_state_t StDrain = 2'd2;

    localparam logic [31:0] PcIncr         = 32'd4;
    localparam logic [31:0] DefaultResetPc = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } ibuf_entry_t;

endpackage

// File: rtl/fetch_ibuf.sv
// Small synchronous FIFO holding fetched {pc, inst} pairs for decode.
// Flush wins over push and pop; storage resets to zero.
module fetch_ibuf
    import fetch_pkg::*;
#(
    parameter int unsigned Depth = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     push,
    input  ibuf_entry_t              push_entry,
    input  logic                     pop,
    output logic [$clog2(Depth):0]   count,
    output logic                     head_valid,
    output ibuf_entry_t              head
);

    localparam int unsigned PtrW = $clog2(Depth);

    ibuf_entry_t     mem_q [Depth];
    logic [PtrW-1:0] wr_ptr_q;
    logic [PtrW-1:0] rd_ptr_q;
    logic [PtrW:0]   count_q;

    // Depth is a power of two, so pointers wrap naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < Depth; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= push_entry;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            count_q <= count_q + {{PtrW{1'b0}}, push} - {{PtrW{1'b0}}, pop};
        end
    end

    assign count      = count_q;
    assign head_valid = (count_q != '0);
    assign head       = mem_q[rd_ptr_q];

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch controller: owns the PC, issues one-outstanding word fetches,
// queues responses for decode and squashes the old stream on redirect.
module fetch_ctrl
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = DefaultResetPc,
    parameter int unsigned IBUF_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        stall_i,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        inst_valid,
    output logic [31:0] inst_o,
    output logic [31:0] inst_pc
);

    localparam int unsigned CntW           = $clog2(IBUF_DEPTH) + 1;
    localparam logic [31:0] ResetPcAligned = RESET_PC & ~32'd3;

    fetch_state_t state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  outst_pc_q, outst_pc_d;
    logic         outst_q, outst_d;
    logic         drop_q, drop_d;

    logic [CntW-1:0] count;
    logic            rsp_valid;
    logic            gnt_fire;
    logic            pop_req;
    logic            pop;
    logic            push;
    logic            flush;
    logic [31:0]     occupancy;
    ibuf_entry_t     head;

    // Responses only count while a request is outstanding; strays are ignored.
    assign rsp_valid = imem_rvalid && outst_q;
    assign pop_req   = inst_valid && !stall_i;
    assign pop       = pop_req && !redirect_valid;
    assign occupancy = 32'(count) + 32'(outst_q) - 32'(pop_req);

    assign imem_req = (state_q != StIdle)
                   && (!outst_q || imem_rvalid)
                   && (!drop_q || rsp_valid)
                   && (occupancy < IBUF_DEPTH);
    assign imem_addr = pc_q;
    assign gnt_fire  = imem_req && imem_gnt;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        outst_d    = outst_q;
        outst_pc_d = outst_pc_q;
        drop_d     = drop_q;
        push       = 1'b0;
        flush      = 1'b0;

        if (gnt_fire) begin
            outst_d    = 1'b1;
            outst_pc_d = pc_q;
        end else if (rsp_valid) begin
            outst_d = 1'b0;
        end

        if (redirect_valid) begin
            pc_d  = redirect_pc & ~32'd3;
            flush = 1'b1;
            // A response still owed to the old stream must be swallowed later.
            if ((outst_q && !imem_rvalid) || gnt_fire) begin
                drop_d  = 1'b1;
                state_d = StDrain;
            end else begin
                drop_d  = 1'b0;
                state_d = StRun;
            end
        end else begin
            if (gnt_fire) begin
                pc_d = pc_q + PcIncr;
            end
            if (rsp_valid) begin
                if (drop_q) begin
                    drop_d  = 1'b0;
                    state_d = StRun;
                end else begin
                    push = 1'b1;
                end
            end
            if (state_q == StIdle) begin
                state_d = StRun;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            pc_q       <= ResetPcAligned;
            outst_q    <= 1'b0;
            outst_pc_q <= '0;
            drop_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            outst_q    <= outst_d;
            outst_pc_q <= outst_pc_d;
            drop_q     <= drop_d;
        end
    end

    fetch_ibuf #(
        .Depth (IBUF_DEPTH)
    ) u_ibuf (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .push       (push),
        .push_entry ('{pc: outst_pc_q, inst: imem_rdata}),
        .pop        (pop),
        .count      (count),
        .head_valid (inst_valid),
        .head       (head)
    );

    assign inst_o  = head.inst;
    assign inst_pc = head.pc;

endmodule
